yutorina_rst_seq: RTL

//   Chip reset sequencer: consumes the clock generator's power-on reset, the raw

---
 rtl/yutorina_rst_pkg.sv | 40 ++++
 rtl/yutorina_debounce.sv | 55 +++++
 rtl/yutorina_rst_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/yutorina_rst_pkg.sv
// rtl/yutorina_rst_pkg.sv - shared state codes, cause codes and helpers for the reset sequencer
// Contents:
//   state_e            sequencer state encoding (ASSERT / REL_BUS / RUN)
//   CAUSE_*            reset cause codes reported on rst_cause
//   cnt_width()        width of the shared hold/stagger counter
//   pick_cause()       priority encode simultaneous requests
package yutorina_rst_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_REL_BUS = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    localparam int CAUSE_W = 2;

    localparam logic [CAUSE_W-1:0] CAUSE_POR    = 2'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_SWITCH = 2'd1;
    localparam logic [CAUSE_W-1:0] CAUSE_WDT    = 2'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_SOFT   = 2'd3;

    // One counter serves both the hold and the stagger phase, so it is sized
    // for the longer of the two; never narrower than one bit.
    function automatic int cnt_width(input int hold_cyc, input int stagger);
        int m;
        m = (hold_cyc > stagger) ? hold_cyc : stagger;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    // Switch beats watchdog beats soft request when they land together.
    function automatic logic [CAUSE_W-1:0] pick_cause(input logic sw_req, input logic wdt_req);
        if (sw_req) begin
            return CAUSE_SWITCH;
        end else if (wdt_req) begin
            return CAUSE_WDT;
        end
        return CAUSE_SOFT;
    endfunction

endpackage

// File: rtl/yutorina_debounce.sv
// rtl/yutorina_debounce.sv - board switch synchronizer, debouncer and rising-edge pulse
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   din   in  raw asynchronous switch level
//   dout  out debounced level
//   rise  out one-cycle pulse when the debounced level goes 0 -> 1
module yutorina_debounce #(
    parameter int DB_W      = 16,
    parameter int DB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic            sync1;
    logic            sync2;
    logic            level;
    logic [DB_W-1:0] db_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            level  <= 1'b0;
            db_cnt <= '0;
            rise   <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            rise  <= 1'b0;
            // Count consecutive cycles the synced input disagrees with the
            // accepted level; a single agreeing cycle starts over.
            if (sync2 != level) begin
                if (db_cnt == DB_LAST) begin
                    level  <= sync2;
                    db_cnt <= '0;
                    rise   <= sync2;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign dout = level;

endmodule

// File: rtl/yutorina_rst_seq.sv
// rtl/yutorina_rst_seq.sv - chip reset sequencer: ordered bus/core reset release with cause latch
// Ports:
//   clk          in   system clock from clk_gen
//   rst          in   synchronous active-high power-on reset
//   rst_sw       in   raw board reset switch, active-high, bouncy, asynchronous
//   wdt_expire   in   one-cycle watchdog expiry pulse
//   soft_rst_req in   one-cycle CPU soft-reset pulse
//   bus_rst      out  registered reset to bus and peripherals
//   core_rst     out  registered reset to CPU core
//   rst_busy     out  high while the sequence is not in RUN
//   rst_cause    out  last cause: 0 POR, 1 SWITCH, 2 WDT, 3 SOFT
module yutorina_rst_seq
    import yutorina_rst_pkg::*;
#(
    parameter int DB_W      = 16,
    parameter int DB_CYCLES = 50000,
    parameter int HOLD_CYC  = 16,
    parameter int STAGGER   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rst_sw,
    input  logic               wdt_expire,
    input  logic               soft_rst_req,
    output logic               bus_rst,
    output logic               core_rst,
    output logic               rst_busy,
    output logic [CAUSE_W-1:0] rst_cause
);

    localparam int               CNT_W     = cnt_width(HOLD_CYC, STAGGER);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [CAUSE_W-1:0] cause_d;
    logic               bus_rst_d;
    logic               core_rst_d;
    logic               busy_d;

    logic               sw_req;
    logic               req;

    yutorina_debounce #(
        .DB_W      (DB_W),
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  (rst_sw),
        .dout (),
        .rise (sw_req)
    );

    // The soft request comes from the core itself, so it can only be honoured
    // while the core is running.
    assign req = sw_req | wdt_expire | (soft_rst_req & (state_q == ST_RUN));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ASSERT;
            cnt_q     <= '0;
            rst_cause <= CAUSE_POR;
            bus_rst   <= 1'b1;
            core_rst  <= 1'b1;
            rst_busy  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_cause <= cause_d;
            bus_rst   <= bus_rst_d;
            core_rst  <= core_rst_d;
            rst_busy  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = rst_cause;
        if (req) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            cause_d = pick_cause(sw_req, wdt_expire);
        end else begin
            unique case (state_q)
                ST_ASSERT: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_REL_BUS;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_REL_BUS: begin
                    if (cnt_q == STAG_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they move
    // on the same edge as the state and never glitch.
    always_comb begin
        bus_rst_d  = (state_d == ST_ASSERT);
        core_rst_d = (state_d != ST_RUN);
        busy_d     = (state_d != ST_RUN);
    end

endmodule
